fb_mem_arbiter: RTL and testbench

Single-port frame/data memory arbiter for the SIMD pipeline. It shares one synchronous-read RAM between the pipeline's memory stage (loads/stores) and the VGA pixel path, which drains an internal prefetch FIFO. The block sits between the pipeline MEM stage, the pixel RAM and the VGA output logic. It drives the pipeline stall (`Stuck`) whenever a CPU access is pending and not yet acknowledged.

---
 rtl/fb_pkg.sv | 10 +
 rtl/fb_mem_arbiter_pix_fifo.sv | 65 ++++++
 rtl/fb_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_fb_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default frame geometry for the frame/data memory arbiter.
package fb_pkg;

  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DISP} grant_e;
  typedef enum logic {C_IDLE, C_ACK} cpu_state_e;

  localparam int DEF_PIX_BASE    = 0;
  localparam int DEF_FRAME_WORDS = 76800;

endpackage

// File: rtl/fb_mem_arbiter_pix_fifo.sv
// Pixel prefetch FIFO: synchronous, simultaneous push/pop, flush clears pointers.
module pix_fifo import fb_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [PW:0]       count,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              do_pop;

  // A pop on an empty FIFO is ignored so the head word holds still.
  assign do_pop = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !do_pop) count_d = count_q + (PW+1)'(1);
      else if (!push && do_pop) count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fb_mem_arbiter.sv
// Shares one synchronous-read RAM between the MEM-stage CPU port and the VGA
// prefetch FIFO; display fills preempt the CPU only when the FIFO runs low.
module fb_mem_arbiter import fb_pkg::*; #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOW_WATER   = 2,
  parameter int PIX_BASE    = DEF_PIX_BASE,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  output logic              dbg_cpu_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] FA_FIRST = ADDR_W'(PIX_BASE);
  localparam logic [ADDR_W-1:0] FA_LAST  = ADDR_W'(PIX_BASE + FRAME_WORDS - 1);

  // Handshake: cpu_req is held by the MEM stage until the one-cycle cpu_ack;
  // pix_pop consumes pix_data only while pix_valid is high.
  cpu_state_e        state_q, state_d;
  logic              ld_q, ld_d;
  logic              disp_q, disp_d;
  logic              go_q, go_d;
  logic              underrun_q, underrun_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  grant_e            gnt;
  logic [CW-1:0]     fifo_count, occ;
  logic              fifo_empty, go_rise, eligible, urgent, push;

  assign go_rise  = go & ~go_q;
  assign occ      = fifo_count + CW'(disp_q);
  assign eligible = go & ~go_rise & (occ < CW'(FIFO_DEPTH));
  assign urgent   = eligible & (occ <= CW'(LOW_WATER));
  // Reads in flight across a go restart belong to the old frame and are dropped.
  assign push     = disp_q & ~go_rise;

  always_comb begin
    gnt = GNT_NONE;
    if (!reset) gnt = GNT_NONE;
    else if (urgent) gnt = GNT_DISP;
    else if (cpu_req && state_q == C_IDLE) gnt = GNT_CPU;
    else if (eligible) gnt = GNT_DISP;
  end

  always_comb begin
    mem_en    = (gnt != GNT_NONE);
    mem_we    = 1'b0;
    mem_addr  = fa_q;
    mem_wdata = '0;
    if (gnt == GNT_CPU) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    case (state_q)
      C_IDLE: if (gnt == GNT_CPU) begin
        state_d = C_ACK;
        ld_d    = ~cpu_we;
      end
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    disp_d = (gnt == GNT_DISP);
    go_d   = go;
    fa_d   = fa_q;
    if (go_rise) fa_d = FA_FIRST;
    else if (gnt == GNT_DISP) fa_d = (fa_q == FA_LAST) ? FA_FIRST : fa_q + ADDR_W'(1);
    underrun_d = underrun_q | (pix_pop & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= C_IDLE;
      ld_q       <= 1'b0;
      disp_q     <= 1'b0;
      go_q       <= 1'b0;
      fa_q       <= FA_FIRST;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      disp_q     <= disp_d;
      go_q       <= go_d;
      fa_q       <= fa_d;
      underrun_q <= underrun_d;
    end
  end

  assign cpu_ack       = (state_q == C_ACK);
  assign cpu_rdata     = (cpu_ack && ld_q) ? mem_rdata : '0;
  assign stall         = cpu_req & ~cpu_ack;
  assign pix_valid     = ~fifo_empty;
  assign underrun      = underrun_q;
  assign dbg_cpu_state = state_q;

  pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (go_rise),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pix_pop),
    .head      (pix_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a RAM model and queue-based scoreboard.
module tb_fb_mem_arbiter;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam logic [AW-1:0] CPU_A = 18'h100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          pix_pop = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] cpu_rdata, mem_wdata, pix_data;
  logic [AW-1:0] mem_addr;
  logic          cpu_ack, stall, mem_en, mem_we, pix_valid, underrun, dbg_cpu_state;

  logic [DW-1:0] ram [0:1023];
  logic [AW-1:0] exp_fa_q[$];
  logic [DW-1:0] exp_pix_q[$];
  logic [DW:0]   exp_cpu_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_disp = 0;
  int n_pix = 0;
  int base_disp, base_pix;

  fb_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8), .LOW_WATER(2),
    .PIX_BASE(0), .FRAME_WORDS(16)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_pop(pix_pop), .pix_data(pix_data), .pix_valid(pix_valid),
    .underrun(underrun), .dbg_cpu_state(dbg_cpu_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      exp_fa_q.push_back(AW'(i % 16));
      exp_pix_q.push_back(32'hA000_0000 + DW'(i % 16));
    end
  endtask

  // monitor: pops expectations whenever the DUT presents an output
  always begin
    logic [DW:0] e;
    @(negedge clk);
    #3;
    if (mem_en && !mem_we && mem_addr != CPU_A) begin
      n_disp++;
      if (exp_fa_q.size() == 0) check("disp_addr_extra", 64'(exp_fa_q.size()), 64'd1);
      else check("disp_addr", 64'(mem_addr), 64'(exp_fa_q.pop_front()));
    end
    if (pix_valid && pix_pop) begin
      n_pix++;
      if (exp_pix_q.size() == 0) check("pix_extra", 64'(exp_pix_q.size()), 64'd1);
      else check("pix_data", 64'(pix_data), 64'(exp_pix_q.pop_front()));
    end
    if (cpu_ack) begin
      if (exp_cpu_q.size() == 0) check("cpu_ack_extra", 64'(exp_cpu_q.size()), 64'd1);
      else begin
        e = exp_cpu_q.pop_front();
        if (e[DW]) check("cpu_rdata", 64'(cpu_rdata), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + DW'(i);

    // reset state
    repeat (3) tick();
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_pix_data", 64'(pix_data), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);

    // pop on empty right after reset
    reset = 1'b1;
    pix_pop = 1'b1;
    tick();
    pix_pop = 1'b0;
    check("underrun_set", 64'(underrun), 64'd1);
    tick();
    check("underrun_hold", 64'(underrun), 64'd1);
    check("underrun_no_valid", 64'(pix_valid), 64'd0);

    // initial fill: reads 0..7 then idle
    push_frame(8);
    go = 1'b1;
    repeat (12) tick();
    check("fill_idle", 64'(mem_en), 64'd0);
    check("fill_reads_done", 64'(exp_fa_q.size()), 64'd0);
    check("fill_valid", 64'(pix_valid), 64'd1);
    check("fill_head", 64'(pix_data), 64'hA000_0000);

    // store then load with FIFO full
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = CPU_A; cpu_wdata = 32'hDEAD_BEEF;
    exp_cpu_q.push_back({1'b0, 32'h0});
    #1;
    check("st_mem_we", 64'(mem_we), 64'd1);
    check("st_mem_addr", 64'(mem_addr), 64'(CPU_A));
    check("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check("st_stall_T", 64'(stall), 64'd1);
    tick();
    check("st_ack", 64'(cpu_ack), 64'd1);
    check("st_stall_T1", 64'(stall), 64'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("st_ack_pulse", 64'(cpu_ack), 64'd0);
    cpu_req = 1'b1;
    exp_cpu_q.push_back({1'b1, 32'hDEAD_BEEF});
    #1;
    check("ld_mem_en", 64'(mem_en), 64'd1);
    check("ld_mem_we", 64'(mem_we), 64'd0);
    tick();
    check("ld_ack", 64'(cpu_ack), 64'd1);
    check("ld_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    cpu_req = 1'b0;

    // restart the frame, then CPU load contending at occ = 2
    tick();
    go = 1'b0;
    repeat (2) tick();
    exp_fa_q.delete();
    exp_pix_q.delete();
    push_frame(64);
    base_disp = n_disp;
    base_pix = n_pix;
    go = 1'b1;
    tick();
    check("flush_valid", 64'(pix_valid), 64'd0);
    check("restart_en", 64'(mem_en), 64'd1);
    check("restart_addr", 64'(mem_addr), 64'd0);
    tick();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = CPU_A;
    exp_cpu_q.push_back({1'b1, 32'hDEAD_BEEF});
    #1;
    check("urgent_wins_addr", 64'(mem_addr), 64'd2);
    check("urgent_stall0", 64'(stall), 64'd1);
    tick();
    check("cpu_after_urgent_addr", 64'(mem_addr), 64'(CPU_A));
    check("urgent_stall1", 64'(stall), 64'd1);
    tick();
    check("urgent_ack", 64'(cpu_ack), 64'd1);
    check("urgent_stall_done", 64'(stall), 64'd0);
    cpu_req = 1'b0;

    // continuous pop across the frame wrap
    pix_pop = 1'b1;
    repeat (30) tick();
    pix_pop = 1'b0;
    repeat (12) tick();
    check("wrap_reads", 64'(n_disp - base_disp >= 18), 64'd1);
    check("wrap_pops", 64'(n_pix - base_pix >= 18), 64'd1);
    check("refill_idle", 64'(mem_en), 64'd0);
    check("underrun_sticky", 64'(underrun), 64'd1);

    // reset with reads in flight
    pix_pop = 1'b1;
    repeat (3) tick();
    pix_pop = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_no_grant", 64'(mem_en), 64'd0);
    tick();
    check("rst2_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst2_pix_valid", 64'(pix_valid), 64'd0);
    check("rst2_underrun", 64'(underrun), 64'd0);
    check("rst2_pix_data", 64'(pix_data), 64'd0);
    tick();
    check("rst2_no_push", 64'(pix_valid), 64'd0);
    cpu_req = 1'b0;
    go = 1'b0;
    reset = 1'b1;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
